// File: rtl/fpu_pkg.sv
// Shared opcode and FSM state definitions for the FPU issue path.
package fpu_pkg;

   typedef enum logic [1:0] {
      FPU_ADD  = 2'b00,
      FPU_SUB  = 2'b01,
      FPU_MUL  = 2'b10,
      FPU_SQRT = 2'b11
   } fpu_op_e;

   // ADD idles the FPU multi-cycle stage machines
   localparam fpu_op_e FPU_PARK_OP = FPU_ADD;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FLUSH  = 3'd1,
      ST_LAUNCH = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RESP   = 3'd4
   } state_e;

endpackage

// File: rtl/fpu_watchdog.sv
// Cycle counter bounding how long the issue controller waits on the FPU.
module fpu_watchdog #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic timeout
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign timeout = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fpu_issue_controller.sv
// Issues one request to the fixed-point unit and returns its result,
// parking the FPU between operations and bounding the wait with a watchdog.
module fpu_issue_controller
   import fpu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_operand_1,
   input  logic [WIDTH-1:0] req_operand_2,
   input  logic [4:0]       req_rd,
   output logic [WIDTH-1:0] fpu_operand_1,
   output logic [WIDTH-1:0] fpu_operand_2,
   output logic [1:0]       fpu_operation,
   input  logic [WIDTH-1:0] fpu_result,
   input  logic             fpu_ready,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [4:0]       rsp_rd,
   output logic             rsp_error,
   output logic             busy
);

   state_e     state;
   fpu_op_e    op_q;
   logic [4:0] rd_q;
   logic       timeout;

   fpu_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (state == ST_LAUNCH),
      .enable  (state == ST_WAIT),
      .timeout (timeout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         op_q          <= FPU_ADD;
         rd_q          <= '0;
         req_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_error     <= 1'b0;
         rsp_result    <= '0;
         rsp_rd        <= '0;
         busy          <= 1'b0;
         fpu_operation <= FPU_PARK_OP;
         fpu_operand_1 <= '0;
         fpu_operand_2 <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q          <= fpu_op_e'(req_op);
                  rd_q          <= req_rd;
                  fpu_operand_1 <= req_operand_1;
                  fpu_operand_2 <= req_operand_2;
                  fpu_operation <= FPU_PARK_OP;
                  req_ready     <= 1'b0;
                  busy          <= 1'b1;
                  state         <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               fpu_operation <= op_q;
               state         <= ST_LAUNCH;
            end
            // fpu_ready may still reflect the previous op here
            ST_LAUNCH: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (fpu_ready == 1'b1) begin
                  rsp_result    <= fpu_result;
                  rsp_error     <= 1'b0;
                  rsp_rd        <= rd_q;
                  rsp_valid     <= 1'b1;
                  fpu_operation <= FPU_PARK_OP;
                  state         <= ST_RESP;
               end else if (timeout) begin
                  rsp_result    <= '0;
                  rsp_error     <= 1'b1;
                  rsp_rd        <= rd_q;
                  rsp_valid     <= 1'b1;
                  fpu_operation <= FPU_PARK_OP;
                  state         <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_issue_controller.sv
// Directed bench for fpu_issue_controller with a behavioural Q22.10 FPU model.
module tb_fpu_issue_controller;
   import fpu_pkg::*;

   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 64;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [1:0]       req_op = 2'b00;
   logic [WIDTH-1:0] req_operand_1 = '0;
   logic [WIDTH-1:0] req_operand_2 = '0;
   logic [4:0]       req_rd = '0;
   logic [WIDTH-1:0] fpu_operand_1;
   logic [WIDTH-1:0] fpu_operand_2;
   logic [1:0]       fpu_operation;
   logic [WIDTH-1:0] fpu_result;
   logic             fpu_ready;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [WIDTH-1:0] rsp_result;
   logic [4:0]       rsp_rd;
   logic             rsp_error;
   logic             busy;

   int checks = 0;
   int failures = 0;

   logic [1:0]  op_tr [0:127];
   logic [31:0] o1_tr [0:127];
   logic [31:0] o2_tr [0:127];

   fpu_issue_controller #(
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (7)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_operand_1 (req_operand_1),
      .req_operand_2 (req_operand_2),
      .req_rd        (req_rd),
      .fpu_operand_1 (fpu_operand_1),
      .fpu_operand_2 (fpu_operand_2),
      .fpu_operation (fpu_operation),
      .fpu_result    (fpu_result),
      .fpu_ready     (fpu_ready),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_result    (rsp_result),
      .rsp_rd        (rsp_rd),
      .rsp_error     (rsp_error),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // FPU model: ADD/SUB combinational, MUL/SQRT sticky done until parked
   logic [7:0]  m_cnt = '0;
   logic        m_done = 1'b0;
   logic [31:0] m_res = '0;
   logic        stub_mode = 1'b0;
   logic        model_ready;
   logic [31:0] model_result;

   function automatic logic [31:0] isqrt_q(input logic [31:0] a);
      logic [63:0] v, r, b;
      v = 64'(a) << 10;
      r = '0;
      for (int i = 31; i >= 0; i--) begin
         b = r | (64'd1 << i);
         if (b * b <= v) r = b;
      end
      return r[31:0];
   endfunction

   function automatic logic [31:0] mul_q(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] p;
      p = $signed(64'($signed(a))) * $signed(64'($signed(b)));
      return p[41:10];
   endfunction

   always @(posedge clk) begin
      if (fpu_operation == FPU_ADD || fpu_operation == FPU_SUB) begin
         m_cnt  <= '0;
         m_done <= 1'b0;
      end else begin
         m_cnt <= m_cnt + 8'd1;
         if (!m_done && fpu_operation == FPU_MUL && m_cnt == 8'd4) begin
            m_done <= 1'b1;
            m_res  <= mul_q(fpu_operand_1, fpu_operand_2);
         end
         if (!m_done && fpu_operation == FPU_SQRT && m_cnt == 8'd19) begin
            m_done <= 1'b1;
            m_res  <= isqrt_q(fpu_operand_1);
         end
      end
   end

   always_comb begin
      model_ready  = m_done;
      model_result = m_res;
      if (fpu_operation == FPU_ADD) begin
         model_ready  = 1'b1;
         model_result = fpu_operand_1 + fpu_operand_2;
      end else if (fpu_operation == FPU_SUB) begin
         model_ready  = 1'b1;
         model_result = fpu_operand_1 - fpu_operand_2;
      end
   end

   // stub FPU that never becomes ready
   assign fpu_ready  = stub_mode ? 1'b0 : model_ready;
   assign fpu_result = stub_mode ? 32'hA5A5A5A5 : model_result;

   task automatic do_req(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
      @(negedge clk);
      req_valid     = 1'b1;
      req_op        = op;
      req_operand_1 = a;
      req_operand_2 = b;
      req_rd        = rd;
      @(posedge clk);
      #1;
      req_valid     = 1'b0;
      req_operand_1 = 32'hDEADBEEF;
      req_operand_2 = 32'hDEADBEEF;
      req_rd        = 5'd31;
      @(negedge clk);
   endtask

   task automatic wait_rsp(output int k);
      k = 0;
      op_tr[0] = fpu_operation;
      o1_tr[0] = fpu_operand_1;
      o2_tr[0] = fpu_operand_2;
      while (rsp_valid !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
         if (k < 128) begin
            op_tr[k] = fpu_operation;
            o1_tr[k] = fpu_operand_1;
            o2_tr[k] = fpu_operand_2;
         end
      end
      if (rsp_valid !== 1'b1) k = 999;
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #12;
      checks++;
      if ({req_ready, rsp_valid, rsp_error, busy} !== 4'b1000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=1000", {req_ready, rsp_valid, rsp_error, busy});
      end
      checks++;
      if ({rsp_result, rsp_rd, fpu_operation, fpu_operand_1, fpu_operand_2} !== '0) begin
         failures++;
         $display("FAIL reset_data res=%h rd=%h op=%h o1=%h o2=%h exp=0",
                  rsp_result, rsp_rd, fpu_operation, fpu_operand_1, fpu_operand_2);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_add();
      int k;
      do_req(FPU_ADD, 32'h00000C00, 32'h00000400, 5'd5);
      wait_rsp(k);
      checks++;
      if (k != 3) begin
         failures++;
         $display("FAIL add_latency got=%0d exp=3", k);
      end
      checks++;
      if ({op_tr[0], op_tr[1], op_tr[2]} !== 6'b000000) begin
         failures++;
         $display("FAIL add_op_seq got=%b exp=000000", {op_tr[0], op_tr[1], op_tr[2]});
      end
      checks++;
      if ({rsp_result, rsp_rd, rsp_error} !== {32'h00001000, 5'd5, 1'b0}) begin
         failures++;
         $display("FAIL add_rsp got=%h/%0d/%b exp=00001000/5/0", rsp_result, rsp_rd, rsp_error);
      end
      finish_rsp();
   endtask

   task automatic test_mul();
      int k;
      logic ok;
      do_req(FPU_MUL, 32'h00000800, 32'h00000C00, 5'd9);
      wait_rsp(k);
      checks++;
      if (k != 7) begin
         failures++;
         $display("FAIL mul_latency got=%0d exp=7", k);
      end
      ok = (k == 7) && (op_tr[0] == FPU_ADD);
      for (int i = 1; i <= 6; i++) if (op_tr[i] != FPU_MUL) ok = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL mul_op_seq got=%b%b%b%b%b%b%b exp=00101010101010",
                  op_tr[0], op_tr[1], op_tr[2], op_tr[3], op_tr[4], op_tr[5], op_tr[6]);
      end
      ok = 1'b1;
      for (int i = 0; i <= 6; i++)
         if (o1_tr[i] != 32'h800 || o2_tr[i] != 32'hC00) ok = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL mul_operands got=unstable exp=00000800/00000C00");
      end
      checks++;
      if ({rsp_result, rsp_rd, rsp_error} !== {32'h00001800, 5'd9, 1'b0}) begin
         failures++;
         $display("FAIL mul_rsp got=%h/%0d/%b exp=00001800/9/0", rsp_result, rsp_rd, rsp_error);
      end
      finish_rsp();
   endtask

   task automatic test_sqrt();
      int k;
      do_req(FPU_SQRT, 32'h00001000, 32'h0, 5'd3);
      wait_rsp(k);
      checks++;
      if (k > TIMEOUT + 2 || {rsp_result, rsp_error} !== {32'h00000800, 1'b0}) begin
         failures++;
         $display("FAIL sqrt4 got=%h err=%b k=%0d exp=00000800 err=0", rsp_result, rsp_error, k);
      end
      finish_rsp();
      do_req(FPU_SQRT, 32'h00004000, 32'h0, 5'd4);
      wait_rsp(k);
      checks++;
      if (k > TIMEOUT + 2 || {rsp_result, rsp_rd, rsp_error} !== {32'h00001000, 5'd4, 1'b0}) begin
         failures++;
         $display("FAIL sqrt16 got=%h rd=%0d err=%b k=%0d exp=00001000 rd=4 err=0",
                  rsp_result, rsp_rd, rsp_error, k);
      end
      finish_rsp();
   endtask

   task automatic test_timeout();
      int k;
      stub_mode = 1'b1;
      do_req(FPU_SQRT, 32'h00001000, 32'h0, 5'd6);
      wait_rsp(k);
      checks++;
      if (k != TIMEOUT + 2) begin
         failures++;
         $display("FAIL timeout_latency got=%0d exp=%0d", k, TIMEOUT + 2);
      end
      checks++;
      if ({rsp_result, rsp_rd, rsp_error} !== {32'h0, 5'd6, 1'b1}) begin
         failures++;
         $display("FAIL timeout_rsp got=%h/%0d/%b exp=00000000/6/1", rsp_result, rsp_rd, rsp_error);
      end
      finish_rsp();
      stub_mode = 1'b0;
   endtask

   task automatic test_back_to_back();
      int k;
      do_req(FPU_ADD, 32'h00000400, 32'h00000400, 5'd1);
      wait_rsp(k);
      checks++;
      if (k != 3 || rsp_result !== 32'h00000800) begin
         failures++;
         $display("FAIL bp_first got=%h k=%0d exp=00000800 k=3", rsp_result, k);
      end
      req_valid     = 1'b1;
      req_op        = FPU_SUB;
      req_operand_1 = 32'h00001400;
      req_operand_2 = 32'h00000400;
      req_rd        = 5'd7;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({rsp_valid, req_ready, busy, rsp_result, rsp_rd, fpu_operand_1} !==
             {1'b1, 1'b0, 1'b1, 32'h00000800, 5'd1, 32'h00000400}) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got v=%b rr=%b b=%b res=%h rd=%0d o1=%h", i,
                     rsp_valid, req_ready, busy, rsp_result, rsp_rd, fpu_operand_1);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, busy} !== 3'b010) begin
         failures++;
         $display("FAIL bp_release got=%b exp=010", {rsp_valid, req_ready, busy});
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, fpu_operation, fpu_operand_1} !== {1'b1, 2'b00, 32'h00001400}) begin
         failures++;
         $display("FAIL bp_accept got b=%b op=%b o1=%h exp b=1 op=00 o1=00001400",
                  busy, fpu_operation, fpu_operand_1);
      end
      wait_rsp(k);
      checks++;
      if (k != 3 || {rsp_result, rsp_rd} !== {32'h00001000, 5'd7}) begin
         failures++;
         $display("FAIL bp_second got=%h rd=%0d k=%0d exp=00001000 rd=7 k=3", rsp_result, rsp_rd, k);
      end
      finish_rsp();
   endtask

   task automatic test_reset_mid();
      int k;
      do_req(FPU_MUL, 32'h00000800, 32'h00000C00, 5'd2);
      @(negedge clk);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_error, busy, fpu_operation, fpu_operand_1, fpu_operand_2}
          !== {4'b1000, 2'b00, 32'h0, 32'h0}) begin
         failures++;
         $display("FAIL midreset got rr=%b v=%b e=%b b=%b op=%b o1=%h o2=%h", req_ready,
                  rsp_valid, rsp_error, busy, fpu_operation, fpu_operand_1, fpu_operand_2);
      end
      @(negedge clk);
      reset = 1'b0;
      do_req(FPU_SUB, 32'h00000400, 32'h00000C00, 5'd8);
      wait_rsp(k);
      checks++;
      if (k != 3 || {rsp_result, rsp_rd, rsp_error} !== {32'hFFFFF800, 5'd8, 1'b0}) begin
         failures++;
         $display("FAIL post_reset_sub got=%h rd=%0d e=%b k=%0d exp=FFFFF800 rd=8 e=0 k=3",
                  rsp_result, rsp_rd, rsp_error, k);
      end
      finish_rsp();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=hung exp=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      test_reset();
      test_add();
      test_mul();
      test_sqrt();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
